// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop) to
// the keyboard over the shared open-drain clock/data lines, then checks the
// device ACK bit. Lines are only ever pulled low through the *_oe outputs.
//
// Ports:
//   fclk     in   system clock
//   rst      in   asynchronous active-low reset
//   clkin    in   PS/2 clock pad readback (asynchronous)
//   datain   in   PS/2 data pad readback (asynchronous)
//   clk_oe   out  1 = pull PS/2 clock low
//   data_oe  out  1 = pull PS/2 data low
//   wr       in   one-cycle write strobe, accepted only while busy=0
//   wdata    in   command byte, sampled when wr is accepted
//   busy     out  transfer in progress
//   done     out  one-cycle pulse at end of transfer
//   err      out  1 = last transfer timed out or was not ACKed
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | lines released, waiting for wr
// INHIBIT   | clock held low to abort any device transmission
// RTS       | clock and data low (request-to-send, start bit on data)
// SEND      | clock released; shift bits out on device falling edges
// ACK       | wait for next falling edge and sample the device ACK
// WAIT_IDLE | wait for both lines high for 2 cycles, then finish
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       clkin,
  input  logic       datain,
  output logic       clk_oe,
  output logic       data_oe,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One down-counter serves the inhibit, RTS and timeout phases.
  localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    sh_q;
  logic [3:0]    bitcnt_q;
  logic          idle_q;
  logic          clk_oe_q, data_oe_q, busy_q, done_q, err_q;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          data_s1_q, data_s2_q;

  logic fall;
  logic in_xfer;
  logic timeout_hit;

  assign fall        = clk_prev_q & ~clk_s2_q;
  assign in_xfer     = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout_hit = in_xfer && (cnt_q == '0);

  // Synchronizers reset to 1 (idle-high lines) so no false edge follows reset.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= clkin;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= datain;
      data_s2_q  <= data_s1_q;
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      bitcnt_q  <= '0;
      idle_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (timeout_hit) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        err_q     <= 1'b1;
        done_q    <= 1'b1;
        state_q   <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            // busy is still 1 in the done cycle, so a wr there is ignored.
            if (wr && !busy_q) begin
              sh_q     <= {1'b1, ~^wdata, wdata};
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              clk_oe_q <= 1'b1;
              cnt_q    <= CW'(INHIBIT_CYCLES - 1);
              state_q  <= ST_INHIBIT;
            end else begin
              busy_q <= 1'b0;
            end
          end
          ST_INHIBIT: begin
            if (cnt_q == '0) begin
              data_oe_q <= 1'b1;
              cnt_q     <= CW'(RTS_CYCLES - 1);
              state_q   <= ST_RTS;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_RTS: begin
            if (cnt_q == '0) begin
              clk_oe_q <= 1'b0;
              bitcnt_q <= '0;
              cnt_q    <= CW'(TIMEOUT_CYCLES - 1);
              state_q  <= ST_SEND;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_SEND: begin
            cnt_q <= cnt_q - 1'b1;
            if (fall) begin
              data_oe_q <= ~sh_q[0];
              sh_q      <= {1'b0, sh_q[9:1]};
              bitcnt_q  <= bitcnt_q + 1'b1;
              if (bitcnt_q == 4'd9) begin
                state_q <= ST_ACK;
              end
            end
          end
          ST_ACK: begin
            cnt_q <= cnt_q - 1'b1;
            if (fall) begin
              err_q   <= data_s2_q;
              idle_q  <= 1'b0;
              state_q <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            cnt_q <= cnt_q - 1'b1;
            if (clk_s2_q && data_s2_q) begin
              if (idle_q) begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                idle_q <= 1'b1;
              end
            end else begin
              idle_q <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign clk_oe  = clk_oe_q;
  assign data_oe = data_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a simple PS/2
// device model driving the open-drain clock and data lines.
module tb_ps2_host_tx;

  logic       fclk = 1'b0;
  logic       rst;
  logic       clkin, datain;
  logic       clk_oe, data_oe;
  logic       wr;
  logic [7:0] wdata;
  logic       busy, done, err;

  logic dev_clk_low;
  logic dev_data_low;

  int checks = 0;
  int errors = 0;

  assign clkin  = ~(clk_oe | dev_clk_low);
  assign datain = ~(data_oe | dev_data_low);

  always #5 fclk = ~fclk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(16),
    .RTS_CYCLES    (4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .fclk   (fclk),
    .rst    (rst),
    .clkin  (clkin),
    .datain (datain),
    .clk_oe (clk_oe),
    .data_oe(data_oe),
    .wr     (wr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  typedef struct {
    logic [7:0] wd;
    bit         ack;
    bit         par;
    bit         exp_err;
    bit         inject;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input vec_t v);
    int n;
    logic [10:0] smp;
    logic [10:0] exp_frame;
    exp_frame = {1'b1, v.par, v.wd, 1'b0};
    @(negedge fclk);
    wr = 1'b1;
    wdata = v.wd;
    @(negedge fclk);
    wr = 1'b0;
    wdata = 8'h00;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("err_clear_on_wr", 32'(err), 32'd0);
    n = 0;
    while (clk_oe && !data_oe && n < 100) begin
      n++;
      @(negedge fclk);
    end
    chk("inhibit_len", 32'(n), 32'd16);
    n = 0;
    while (clk_oe && data_oe && n < 100) begin
      n++;
      @(negedge fclk);
    end
    chk("rts_len", 32'(n), 32'd4);
    if (v.inject) begin
      wr = 1'b1;
      wdata = 8'h55;
      @(negedge fclk);
      wr = 1'b0;
      wdata = 8'h00;
    end
    repeat (4) @(negedge fclk);
    smp[0] = datain;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (6) @(negedge fclk);
      dev_clk_low = 1'b0;
      repeat (6) @(negedge fclk);
      smp[i] = datain;
    end
    if (v.ack) begin
      dev_data_low = 1'b1;
      repeat (4) @(negedge fclk);
    end
    dev_clk_low = 1'b1;
    repeat (6) @(negedge fclk);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge fclk);
    dev_data_low = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge fclk);
      n++;
    end
    chk("frame_bits", 32'(smp), 32'(exp_frame));
    chk("done_seen", 32'(done), 32'd1);
    chk("err_at_done", 32'(err), 32'(v.exp_err));
    chk("oe_at_done", 32'({clk_oe, data_oe}), 32'd0);
    @(negedge fclk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (5) @(negedge fclk);
    chk("err_held", 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    int n;
    int k;
    vecs[0] = '{wd: 8'hED, ack: 1'b1, par: 1'b1, exp_err: 1'b0, inject: 1'b0};
    vecs[1] = '{wd: 8'h00, ack: 1'b1, par: 1'b1, exp_err: 1'b0, inject: 1'b0};
    vecs[2] = '{wd: 8'h01, ack: 1'b1, par: 1'b0, exp_err: 1'b0, inject: 1'b0};
    vecs[3] = '{wd: 8'hED, ack: 1'b0, par: 1'b1, exp_err: 1'b1, inject: 1'b0};
    vecs[4] = '{wd: 8'hED, ack: 1'b1, par: 1'b1, exp_err: 1'b0, inject: 1'b1};
    vecs[5] = '{wd: 8'hFF, ack: 1'b1, par: 1'b1, exp_err: 1'b0, inject: 1'b0};

    rst = 1'b0;
    wr = 1'b0;
    wdata = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge fclk);
    chk("reset_outputs", 32'({clk_oe, data_oe, busy, done, err}), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge fclk);

    for (int i = 0; i < 5; i++) begin
      xfer(vecs[i]);
    end

    // Timeout: device never clocks after the clock is released.
    @(negedge fclk);
    wr = 1'b1;
    wdata = 8'hA5;
    @(negedge fclk);
    wr = 1'b0;
    n = 0;
    while (clk_oe && n < 100) begin
      @(negedge fclk);
      n++;
    end
    k = 0;
    while (!done && k < 1000) begin
      @(negedge fclk);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'd200);
    chk("timeout_oe", 32'({clk_oe, data_oe}), 32'd0);
    chk("timeout_err", 32'(err), 32'd1);
    @(negedge fclk);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_done_pulse", 32'(done), 32'd0);
    repeat (10) @(negedge fclk);
    chk("timeout_err_held", 32'(err), 32'd1);

    // Asynchronous reset in the middle of SEND.
    @(negedge fclk);
    wr = 1'b1;
    wdata = 8'hED;
    @(negedge fclk);
    wr = 1'b0;
    n = 0;
    while (clk_oe && n < 100) begin
      @(negedge fclk);
      n++;
    end
    repeat (3) @(negedge fclk);
    chk("pre_reset_start_bit", 32'({clk_oe, data_oe, busy}), 32'b011);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", 32'({clk_oe, data_oe, busy, done, err}), 32'd0);
    @(negedge fclk);
    rst = 1'b1;
    repeat (3) @(negedge fclk);

    xfer(vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "global timeout");
  end

endmodule
